load_store_unit: RTL

CPU-side initiator for the word-only `memory_interface` data port: accepts one load/store per request from the execute/memory stage and drives the memory's `addr`/`din`/`write`. Sub-word stores are done as read-modify-write because the memory has no byte enables. Performs MIPS little-endian lane extraction with sign/zero extension, alignment checking, and stalling on memory `busy`.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the data-side load/store path: memory operation encodings
// and the load/store unit state machine states.
package lsu_pkg;

    localparam int MEM_OPS = 8;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_e;

    function automatic logic is_load(input mem_op_e o);
        return o inside {LB, LBU, LH, LHU, LW};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for a word-only memory: load extraction with
// sign/zero extension, sub-word merge for read-modify-write, alignment check.
module mem_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b     = word[8*addr_lo +: 8];
        lane_h     = word[16*addr_lo[1] +: 16];
        load_val   = word;
        store_word = word;
        misaligned = 1'b0;

        case (mem_op_e'(op))
            LB:      load_val = 32'(lane_b);
            LBU:     load_val = {24'd0, lane_b};
            LH:      load_val = 32'(lane_h);
            LHU:     load_val = {16'd0, lane_h};
            SB:      store_word[8*addr_lo +: 8] = wdata[7:0];
            SH:      store_word[16*addr_lo[1] +: 16] = wdata;
            default: load_val = word;
        endcase

        case (mem_op_e'(op))
            LH, LHU, SH: misaligned = addr_lo[0];
            LW, SW:      misaligned = |addr_lo;
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-port initiator: one load/store per request, sub-word stores as
// read-modify-write, stalls on mem_busy, one-cycle done pulse per request.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_write,
    input  logic [31:0] mem_dout,
    input  logic        mem_busy
);

    lsu_state_e  state_q, state_d;
    mem_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;

    logic [2:0]  al_op;
    logic [1:0]  al_addr;
    logic [31:0] al_word;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        misaligned;
    logic [31:0] word_addr;

    // In IDLE the aligner checks the incoming request; afterwards it works
    // on the registered request and, in RMW_WR, on the buffered raw word.
    assign al_op     = (state_q == IDLE) ? op : op_q;
    assign al_addr   = (state_q == IDLE) ? addr[1:0] : addr_q[1:0];
    assign al_word   = (state_q == RMW_WR) ? merge_q : mem_dout;
    assign word_addr = {addr_q[31:2], 2'b00};
    assign rdata     = rdata_q;

    mem_lane_align u_align (
        .op         (al_op),
        .addr_lo    (al_addr),
        .word       (al_word),
        .wdata      (wdata_q[15:0]),
        .load_val   (load_val),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        merge_d   = merge_q;
        ready     = 1'b0;
        done      = 1'b0;
        addr_err  = 1'b0;
        mem_addr  = 32'd0;
        mem_din   = 32'd0;
        mem_write = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    op_d    = mem_op_e'(op);
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (is_load(mem_op_e'(op))) begin
                        state_d = RD;
                    end else if (mem_op_e'(op) == SW) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD: begin
                mem_addr = word_addr;
                if (!mem_busy) begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WR: begin
                mem_addr  = word_addr;
                mem_din   = wdata_q;
                mem_write = !reset;
                if (!mem_busy) state_d = RESP;
            end
            RMW_RD: begin
                mem_addr = word_addr;
                if (!mem_busy) begin
                    merge_d = mem_dout;
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                // Strobe is masked during reset so an abandoned merge never lands.
                mem_addr  = word_addr;
                mem_din   = store_word;
                mem_write = !reset;
                if (!mem_busy) state_d = RESP;
            end
            RESP: begin
                done     = 1'b1;
                addr_err = err_q;
                err_d    = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= LB;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

endmodule
